// File: rtl/adder_share_arb.sv
// adder_share_arb: time-shares one external registered adder among NUM_REQ
// requesters. Round-robin issue, a tag pipe that tracks which requester owns
// each sum in flight, and an in-order response FIFO. Issue is credit-limited
// so that every sum in flight always has a FIFO slot waiting for it.
module adder_share_arb #(
    parameter int NUM_REQ       = 4,
    parameter int WIDTH         = 16,
    parameter int ADDER_LATENCY = 1,
    parameter int RSP_DEPTH     = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [WIDTH-1:0]         add_a,
    output logic [WIDTH-1:0]         add_b,
    input  logic [WIDTH:0]           add_sum,
    output logic [NUM_REQ-1:0]       rsp_valid,
    input  logic [NUM_REQ-1:0]       rsp_ready,
    output logic [WIDTH:0]           rsp_sum
);

    localparam int IDXW = $clog2(NUM_REQ);
    localparam int CNTW = $clog2(RSP_DEPTH + 1);
    localparam int PTRW = $clog2(RSP_DEPTH);

    logic [IDXW-1:0] rr_ptr;
    logic [IDXW-1:0] winner;
    logic [NUM_REQ-1:0] grant;
    logic            found;
    logic            issue_ok;
    logic            pop;
    logic            push;
    logic [CNTW-1:0] occ;
    logic [CNTW-1:0] fifo_cnt;
    logic [CNTW-1:0] pipe_cnt;
    logic [PTRW-1:0] rd_ptr;
    logic [PTRW-1:0] wr_ptr;

    logic            pipe_vld [ADDER_LATENCY];
    logic [IDXW-1:0] pipe_tag [ADDER_LATENCY];

    logic [IDXW-1:0] fifo_tag [RSP_DEPTH];
    logic [WIDTH:0]  fifo_sum [RSP_DEPTH];

    assign pop = |(rsp_valid & rsp_ready);

    // A slot freed by this cycle's pop may be reused immediately; reset
    // holds off issue while rst_n is low.
    assign issue_ok = rst_n && ((occ < CNTW'(RSP_DEPTH)) || pop);

    // Round-robin scan starting at rr_ptr; only valid requesters are granted.
    always_comb begin
        int idx;
        idx    = 0;
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!found && issue_ok && req_valid[idx]) begin
                found       = 1'b1;
                grant[idx]  = 1'b1;
                winner      = IDXW'(idx);
            end
        end
    end

    assign req_ready = grant;

    // Operand mux toward the shared adder; zero when nothing issues.
    always_comb begin
        add_a = '0;
        add_b = '0;
        if (found) begin
            add_a = req_a[int'(winner)*WIDTH +: WIDTH];
            add_b = req_b[int'(winner)*WIDTH +: WIDTH];
        end
    end

    // Round-robin pointer moves just past the winner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (found) begin
            rr_ptr <= (winner == IDXW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
        end
    end

    // Tag pipe mirrors the adder latency so the last stage names add_sum's owner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ADDER_LATENCY; i++) begin
                pipe_vld[i] <= 1'b0;
                pipe_tag[i] <= '0;
            end
        end else begin
            pipe_vld[0] <= found;
            pipe_tag[0] <= winner;
            for (int i = 1; i < ADDER_LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_tag[i] <= pipe_tag[i-1];
            end
        end
    end

    assign push = pipe_vld[ADDER_LATENCY-1];

    // FIFO storage; contents are only observed while the count is non-zero.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_tag[wr_ptr] <= pipe_tag[ADDER_LATENCY-1];
            fifo_sum[wr_ptr] <= add_sum;
        end
    end

    // FIFO pointers and fill count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTRW'(RSP_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTRW'(RSP_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Credit counter: operations issued and not yet handed back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ <= '0;
        end else begin
            case ({found, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    // FIFO head presented to the owning requester only.
    always_comb begin
        rsp_valid = '0;
        rsp_sum   = '0;
        if (fifo_cnt != '0) begin
            rsp_valid[fifo_tag[rd_ptr]] = 1'b1;
            rsp_sum                     = fifo_sum[rd_ptr];
        end
    end

    // Count of live pipe stages, used to cross-check the credit counter.
    always_comb begin
        pipe_cnt = '0;
        for (int i = 0; i < ADDER_LATENCY; i++) begin
            pipe_cnt = pipe_cnt + CNTW'(pipe_vld[i]);
        end
    end

    a_fifo_bound: assert property (@(posedge clk) disable iff (!rst_n)
        fifo_cnt <= CNTW'(RSP_DEPTH));

    a_occ_match: assert property (@(posedge clk) disable iff (!rst_n)
        {1'b0, occ} == {1'b0, pipe_cnt} + {1'b0, fifo_cnt});

endmodule
